mult_div_unit: RTL and testbench

Multicycle signed multiply/divide unit for the multicycle MIPS datapath. It takes operands from the A and B registers and produces 64-bit results on `hi`/`lo`, which load the HI and LO registers under the control unit's `write` strobe. The control unit issues `start` and waits on `done` before leaving the mult/div states. Divide-by-zero is flagged on `div0`, which the control unit routes to its exception path.

---
 rtl/mult_div_unit.sv | 166 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multicycle signed multiply/divide unit (Booth radix-2 mult, restoring div)
// Optional macro MULT_DIV_UNSIGNED_EN adds multu/divu selected by op[1].
module mult_div_unit #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div0
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [32:0] acc_q;
  logic [31:0] pl_q;
  logic [31:0] m_q;
  logic        qm1_q;
  logic        div_q;
  logic        uns_q;
  logic        q_neg_q;
  logic        r_neg_q;
  logic        div0_pend_q;

  logic        is_uns;
  logic        is_div;
  logic        accept;
  logic        zero_div;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

`ifdef MULT_DIV_UNSIGNED_EN
  assign is_uns = op[1];
`else
  logic unused_op1;
  assign unused_op1 = op[1];
  assign is_uns     = 1'b0;
`endif

  assign is_div   = op[0];
  assign accept   = (state_q == IDLE) && start;
  assign zero_div = is_div && (b == 32'd0);
  assign a_neg    = ~is_uns & a[31];
  assign b_neg    = ~is_uns & b[31];
  assign a_mag    = a_neg ? (32'd0 - a) : a;
  assign b_mag    = b_neg ? (32'd0 - b) : b;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !zero_div) state_d = RUN;
      RUN:     if (cnt_q == 5'd0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One iteration of each algorithm; acc is 33 bits so Booth never overflows on -2^31.
  logic [32:0] m_ext, booth_sum, r_shift;
  logic [33:0] diff;

  always_comb begin
    m_ext     = uns_q ? {1'b0, m_q} : {m_q[31], m_q};
    booth_sum = acc_q;
    if (uns_q) begin
      if (pl_q[0]) booth_sum = acc_q + m_ext;
    end else begin
      case ({pl_q[0], qm1_q})
        2'b01:   booth_sum = acc_q + m_ext;
        2'b10:   booth_sum = acc_q - m_ext;
        default: booth_sum = acc_q;
      endcase
    end
    r_shift = {acc_q[31:0], pl_q[31]};
    diff    = {1'b0, r_shift} - {2'b00, m_q};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      acc_q       <= 33'd0;
      pl_q        <= 32'd0;
      m_q         <= 32'd0;
      qm1_q       <= 1'b0;
      div_q       <= 1'b0;
      uns_q       <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      div0_pend_q <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div0        <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      div0    <= 1'b0;
      if (div0_pend_q) begin
        done        <= 1'b1;
        div0        <= 1'b1;
        div0_pend_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            div_q <= is_div;
            uns_q <= is_uns;
            if (zero_div) begin
              div0_pend_q <= 1'b1;
            end else begin
              busy  <= 1'b1;
              cnt_q <= 5'(ITER - 1);
              acc_q <= 33'd0;
              qm1_q <= 1'b0;
              if (is_div) begin
                pl_q    <= a_mag;
                m_q     <= b_mag;
                q_neg_q <= a_neg ^ b_neg;
                r_neg_q <= a_neg;
              end else begin
                pl_q    <= b;
                m_q     <= a;
                q_neg_q <= 1'b0;
                r_neg_q <= 1'b0;
              end
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q - 5'd1;
          if (div_q) begin
            acc_q <= diff[33] ? r_shift : diff[32:0];
            pl_q  <= {pl_q[30:0], ~diff[33]};
          end else begin
            acc_q <= {~uns_q & booth_sum[32], booth_sum[32:1]};
            pl_q  <= {booth_sum[0], pl_q[31:1]};
            qm1_q <= pl_q[0];
          end
        end
        FIX: begin
          if (div_q) begin
            lo <= q_neg_q ? (32'd0 - pl_q) : pl_q;
            hi <= r_neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
          end else begin
            lo <= pl_q;
            hi <= acc_q[31:0];
          end
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] hi, lo;
  logic        busy, done, div0;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit #(.ITER(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div0(div0)
  );

  always #5 clk = ~clk;

  function automatic void ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] ph, input logic [31:0] pl,
                                 output logic [31:0] rh, output logic [31:0] rl, output logic z);
    logic uns;
    longint sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    logic [63:0] p;
`ifdef MULT_DIV_UNSIGNED_EN
    uns = o[1];
`else
    uns = 1'b0;
`endif
    z  = o[0] && (y == 32'd0);
    rh = ph;
    rl = pl;
    if (z) return;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (!o[0]) begin
      if (uns) p = ux * uy;
      else     p = sx * sy;
      rh = p[63:32];
      rl = p[31:0];
    end else if (uns) begin
      uq = ux / uy;
      ur = ux % uy;
      rl = uq[31:0];
      rh = ur[31:0];
    end else begin
      sq = sx / sy;
      sr = sx % sy;
      rl = sq[31:0];
      rh = sr[31:0];
    end
  endfunction

  // Call at a negedge; returns at the negedge just after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && cycles < 100) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 100) begin
      total_cnt++;
      $display("FAIL wait_done timeout: no done after %0d cycles, required within 100", cycles);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo: got %h_%h, required 0", hi, lo);
    else pass_cnt++;
    total_cnt++;
    if ({busy, done, div0} !== 3'b000) $display("FAIL reset_flags: busy/done/div0 got %b, required 000", {busy, done, div0});
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult;
    logic [31:0] xs [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd3};
    logic [31:0] ys [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd5};
    logic [63:0] ex [4] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000, 64'h0000_0000_0000_0001, 64'd15};
    int cyc, bcyc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      issue(2'b00, xs[i], ys[i]);
      wait_done(cyc, bcyc);
      total_cnt++;
      if ({hi, lo} !== ex[i]) $display("FAIL mult_%0d: got %h_%h, required %h", i, hi, lo, ex[i]);
      else pass_cnt++;
      total_cnt++;
      if (cyc != 33 || bcyc != 33) $display("FAIL mult_timing_%0d: latency %0d busy %0d, required 33 33", i, cyc, bcyc);
      else pass_cnt++;
      m_hi = ex[i][63:32];
      m_lo = ex[i][31:0];
    end
  endtask

  task automatic test_div;
    logic [31:0] xs [4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd256};
    logic [31:0] ys [4] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] eq [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'd36};
    logic [31:0] er [4] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd4};
    int cyc, bcyc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      issue(2'b01, xs[i], ys[i]);
      wait_done(cyc, bcyc);
      total_cnt++;
      if (lo !== eq[i] || hi !== er[i] || div0 !== 1'b0)
        $display("FAIL div_%0d: got lo=%h hi=%h div0=%b, required lo=%h hi=%h div0=0", i, lo, hi, div0, eq[i], er[i]);
      else pass_cnt++;
      total_cnt++;
      if (cyc != 33) $display("FAIL div_latency_%0d: got %0d, required 33", i, cyc);
      else pass_cnt++;
      m_hi = er[i];
      m_lo = eq[i];
    end
  endtask

  task automatic test_div0;
    int cyc, bcyc;
    @(negedge clk);
    issue(2'b00, 32'd3, 32'd5);
    wait_done(cyc, bcyc);
    @(negedge clk);
    issue(2'b01, 32'h1234_5678, 32'd0);
    wait_done(cyc, bcyc);
    total_cnt++;
    if (cyc != 1 || div0 !== 1'b1 || bcyc != 0)
      $display("FAIL div0_pulse: latency %0d div0 %b busy %0d, required 1 1 0", cyc, div0, bcyc);
    else pass_cnt++;
    total_cnt++;
    if (hi !== 32'd0 || lo !== 32'd15) $display("FAIL div0_hold: got %h_%h, required 0_f", hi, lo);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || div0 !== 1'b0 || busy !== 1'b0)
      $display("FAIL div0_single: done/div0/busy got %b%b%b, required 000", done, div0, busy);
    else pass_cnt++;
    m_hi = 32'd0;
    m_lo = 32'd15;
  endtask

  task automatic test_back_to_back;
    int cyc, bcyc;
    @(negedge clk);
    issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, bcyc);
    total_cnt++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0 || div0 !== 1'b0)
      $display("FAIL b2b_div: got lo=%h hi=%h div0=%b, required 80000000 0 0", lo, hi, div0);
    else pass_cnt++;
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_done(cyc, bcyc);
    total_cnt++;
    if (hi !== 32'h4000_0000 || lo !== 32'd0 || cyc != 33)
      $display("FAIL b2b_mult: got %h_%h latency %0d, required 40000000_0 33", hi, lo, cyc);
    else pass_cnt++;
    m_hi = 32'h4000_0000;
    m_lo = 32'd0;
  endtask

  task automatic test_reset_mid_run;
    int dones = 0;
    @(negedge clk);
    issue(2'b00, 32'd12345, 32'd6789);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0)
      $display("FAIL reset_mid_run: busy=%b done=%b hi=%h lo=%h, required all 0", busy, done, hi, lo);
    else pass_cnt++;
    reset = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    total_cnt++;
    if (dones != 0) $display("FAIL reset_discard: got %0d done pulses, required 0", dones);
    else pass_cnt++;
  endtask

  task automatic test_ignored_start;
    int cyc, bcyc, dones;
    logic [31:0] eh, el;
    logic ez;
    ref_op(2'b00, 32'hDEAD_BEEF, 32'h0000_1234, m_hi, m_lo, eh, el, ez);
    @(negedge clk);
    issue(2'b00, 32'hDEAD_BEEF, 32'h0000_1234);
    repeat (5) @(negedge clk);
    issue(2'b01, 32'd99, 32'd0);
    wait_done(cyc, bcyc);
    total_cnt++;
    if (hi !== eh || lo !== el || div0 !== 1'b0)
      $display("FAIL ignored_start_result: got %h_%h div0=%b, required %h_%h 0", hi, lo, div0, eh, el);
    else pass_cnt++;
    m_hi = eh;
    m_lo = el;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    total_cnt++;
    if (dones != 0) $display("FAIL ignored_start_queued: got %0d extra done pulses, required 0", dones);
    else pass_cnt++;
  endtask

  task automatic test_unsigned_op;
    int cyc, bcyc;
    logic [31:0] ehi;
`ifdef MULT_DIV_UNSIGNED_EN
    ehi = 32'd1;
`else
    ehi = 32'hFFFF_FFFF;
`endif
    @(negedge clk);
    issue(2'b10, 32'hFFFF_FFFF, 32'd2);
    wait_done(cyc, bcyc);
    total_cnt++;
    if (hi !== ehi || lo !== 32'hFFFF_FFFE || cyc != 33)
      $display("FAIL unsigned_op: got %h_%h latency %0d, required %h_fffffffe 33", hi, lo, cyc, ehi);
    else pass_cnt++;
    m_hi = ehi;
    m_lo = 32'hFFFF_FFFE;
  endtask

  task automatic test_random;
    int cyc, bcyc;
    logic [1:0]  o;
    logic [31:0] x, y, eh, el;
    logic ez;
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       begin x = $urandom; y = $urandom; end
        1:       begin x = 32'($urandom_range(0, 200)) - 32'd100; y = 32'($urandom_range(0, 20)) - 32'd10; end
        2:       begin x = $urandom; y = 32'($urandom_range(0, 40)); end
        default: begin x = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'($urandom)}; y = $urandom; end
      endcase
      if (o[0] && $urandom_range(0, 7) == 0) y = 32'd0;
      ref_op(o, x, y, m_hi, m_lo, eh, el, ez);
      issue(o, x, y);
      wait_done(cyc, bcyc);
      total_cnt++;
      if (hi !== eh || lo !== el || div0 !== ez || cyc != (ez ? 1 : 33))
        $display("FAIL random_%0d op=%b a=%h b=%h: got %h_%h div0=%b lat=%0d, required %h_%h div0=%b lat=%0d",
                 i, o, x, y, hi, lo, div0, cyc, eh, el, ez, ez ? 1 : 33);
      else pass_cnt++;
      m_hi = eh;
      m_lo = el;
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div0;
    test_back_to_back;
    test_reset_mid_run;
    test_ignored_start;
    test_unsigned_op;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
